hilo_muldiv_ctrl: RTL and testbench

//  Sequencer for the HI/LO resource. Owns the 64-bit HI/LO register pair that

---
 rtl/hilo_muldiv_ctrl_if.sv | 18 +
 rtl/hilo_muldiv_ctrl.sv | 104 ++++++++++
 tb/tb_hilo_muldiv_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/hilo_muldiv_ctrl_if.sv
// hilo_muldiv_ctrl_if: decode-side handshake and HI/LO result bus for the HI/LO sequencer
interface hilo_muldiv_ctrl_if;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        rd_req;
  logic        flush;
  logic        op_ready;
  logic        busy;
  logic        stall;
  logic        done;
  logic [63:0] hilo_out;
  modport master (output op_valid, op, rs_data, rt_data, rd_req, flush,
                  input  op_ready, busy, stall, done, hilo_out);
  modport slave  (input  op_valid, op, rs_data, rt_data, rd_req, flush,
                  output op_ready, busy, stall, done, hilo_out);
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: HI/LO sequencer with multi-cycle mul/div and MTHI/MTLO.
// HILO_FWD_EN: forward the completing result onto hilo_out and drop the rd_req stall in that cycle.
module hilo_muldiv_ctrl #(
  parameter int MUL_LAT = 4
) (
  input logic                clk,
  input logic                rst,
  hilo_muldiv_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  state_t      r_state, w_next;
  logic [63:0] r_hilo;
  logic [31:0] r_a, r_b, r_quo, r_rem, r_dvs;
  logic [4:0]  r_cnt;
  logic        r_sgn, r_qneg, r_rneg, r_fix, r_done;
  logic        w_acc, w_is_mul, w_is_div, w_sgn_in, w_fin, w_wr, w_ge, w_msgn;
  logic [31:0] w_ma, w_mb, w_q, w_r;
  logic [32:0] w_sh, w_sub;
  logic [63:0] w_prod, w_dres, w_res;
  assign w_acc    = (r_state == IDLE) & bus.op_valid & ~bus.flush;
  assign w_is_mul = (bus.op == 3'b001) | (bus.op == 3'b010);
  assign w_is_div = (bus.op == 3'b011) | (bus.op == 3'b100);
  assign w_sgn_in = (bus.op == 3'b001) | (bus.op == 3'b011);
  assign w_fin    = ((r_state == MUL) & (r_cnt == 5'd0)) | ((r_state == DIV) & r_fix);
  assign w_wr     = w_fin & ~bus.flush;
  // The IDLE path feeds the multiplier straight from the operands so MUL_LAT==1 can write at accept.
  assign w_ma   = (r_state == IDLE) ? bus.rs_data : r_a;
  assign w_mb   = (r_state == IDLE) ? bus.rt_data : r_b;
  assign w_msgn = (r_state == IDLE) ? w_sgn_in : r_sgn;
  assign w_prod = {{32{w_msgn & w_ma[31]}}, w_ma} * {{32{w_msgn & w_mb[31]}}, w_mb};
  assign w_sh   = {r_rem, r_quo[31]};
  assign w_sub  = w_sh - {1'b0, r_dvs};
  assign w_ge   = ~w_sub[32];
  assign w_q    = r_qneg ? -r_quo : r_quo;
  assign w_r    = r_rneg ? -r_rem : r_rem;
  assign w_dres = (r_b == 32'd0) ? {r_a, 32'hFFFF_FFFF} : {w_r, w_q};
  assign w_res  = (r_state == DIV) ? w_dres : w_prod;
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE) ? ((w_acc & w_is_div) ? DIV :
                                  (w_acc & w_is_mul & (MUL_LAT > 1)) ? MUL : IDLE) :
             (bus.flush | w_fin) ? IDLE : r_state;
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hilo <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_quo  <= '0;
      r_rem  <= '0;
      r_dvs  <= '0;
      r_cnt  <= '0;
      r_sgn  <= 1'b0;
      r_qneg <= 1'b0;
      r_rneg <= 1'b0;
      r_fix  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_acc) begin
        if (bus.op == 3'b101) r_hilo[63:32] <= bus.rs_data;
        if (bus.op == 3'b110) r_hilo[31:0]  <= bus.rs_data;
        if (w_is_mul && MUL_LAT == 1) begin
          r_hilo <= w_prod;
          r_done <= 1'b1;
        end
        r_a    <= bus.rs_data;
        r_b    <= bus.rt_data;
        r_sgn  <= w_sgn_in;
        r_cnt  <= w_is_div ? 5'd31 : 5'(MUL_LAT - 1);
        r_quo  <= (w_sgn_in & bus.rs_data[31]) ? -bus.rs_data : bus.rs_data;
        r_dvs  <= (w_sgn_in & bus.rt_data[31]) ? -bus.rt_data : bus.rt_data;
        r_rem  <= '0;
        r_qneg <= w_sgn_in & (bus.rs_data[31] ^ bus.rt_data[31]);
        r_rneg <= w_sgn_in & bus.rs_data[31];
        r_fix  <= (bus.rt_data == 32'd0);
      end else if (w_wr) begin
        r_hilo <= w_res;
        r_done <= 1'b1;
      end else if (r_state == MUL) begin
        r_cnt <= r_cnt - 5'd1;
      end else if (r_state == DIV) begin
        r_rem <= w_ge ? w_sub[31:0] : w_sh[31:0];
        r_quo <= {r_quo[30:0], w_ge};
        r_cnt <= r_cnt - 5'd1;
        if (r_cnt == 5'd0) r_fix <= 1'b1;
      end
    end
  end
  assign bus.op_ready = (r_state == IDLE);
  assign bus.busy     = (r_state != IDLE);
  assign bus.done     = r_done;
`ifdef HILO_FWD_EN
  assign bus.hilo_out = w_wr ? w_res : r_hilo;
  assign bus.stall    = bus.busy & (bus.op_valid | (bus.rd_req & ~w_wr));
`else
  assign bus.hilo_out = r_hilo;
  assign bus.stall    = bus.busy & (bus.op_valid | bus.rd_req);
`endif
endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// tb_hilo_muldiv_ctrl: directed vectors for the HI/LO sequencer
module tb_hilo_muldiv_ctrl;
  localparam int MUL_LAT = 4;
  localparam logic [2:0] MULT = 3'b001, MULTU = 3'b010, DIVS = 3'b011, DIVU = 3'b100;
  localparam logic [2:0] MTHI = 3'b101, MTLO = 3'b110;
`ifdef HILO_FWD_EN
  localparam int FWD = 1;
`else
  localparam int FWD = 0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n, lo;
  always #5 clk = ~clk;
  hilo_muldiv_ctrl_if bus();
  hilo_muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    bus.op_valid = 1'b1;
    bus.op       = o;
    bus.rs_data  = a;
    bus.rt_data  = b;
    tick;
    bus.op_valid = 1'b0;
  endtask
  task automatic wait_idle(output int cyc, output int nst);
    cyc = 0;
    nst = 0;
    #1;
    while (bus.busy && cyc < 200) begin
      if (!bus.stall) nst++;
      tick;
      #1;
      cyc++;
    end
  endtask
  task automatic mult_case(input string tag);
    issue(MULT, 32'hFFFF_FFFD, 32'd5);
    check({tag, "_busy"}, 64'(bus.busy), 64'd1);
    wait_idle(n, lo);
    check({tag, "_lat"}, 64'(n), 64'(MUL_LAT));
    check({tag, "_hilo"}, bus.hilo_out, 64'hFFFFFFFF_FFFFFFF1);
    check({tag, "_done"}, 64'(bus.done), 64'd1);
    tick;
    check({tag, "_done_once"}, 64'(bus.done), 64'd0);
  endtask
  initial begin
    bus.op_valid = 1'b0;
    bus.op       = 3'b000;
    bus.rs_data  = '0;
    bus.rt_data  = '0;
    bus.rd_req   = 1'b0;
    bus.flush    = 1'b0;
    tick;
    tick;
    check("rst_hilo", bus.hilo_out, 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_ready", 64'(bus.op_ready), 64'd1);
    check("rst_done", 64'(bus.done), 64'd0);
    rst = 1'b0;
    mult_case("mult");
    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(n, lo);
    check("multu_hilo", bus.hilo_out, 64'hFFFFFFFE_00000001);
    issue(MULT, 32'h8000_0000, 32'h8000_0000);
    wait_idle(n, lo);
    check("mult_min_hilo", bus.hilo_out, 64'h40000000_00000000);
    issue(DIVU, 32'd100, 32'd7);
    bus.rd_req = 1'b1;
    #1;
    check("divu_stall", 64'(bus.stall), 64'd1);
    wait_idle(n, lo);
    check("divu_lat", 64'(n), 64'd33);
    check("divu_stall_gap", 64'(lo), 64'(FWD));
    check("divu_stall_drop", 64'(bus.stall), 64'd0);
    check("divu_hilo", bus.hilo_out, {32'd2, 32'd14});
    check("divu_done", 64'(bus.done), 64'd1);
    bus.rd_req = 1'b0;
    issue(DIVS, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n, lo);
    check("div_neg_hilo", bus.hilo_out, 64'hFFFFFFFF_FFFFFFFD);
    issue(DIVS, 32'd7, 32'd0);
    wait_idle(n, lo);
    check("div0_lat", 64'(n), 64'd1);
    check("div0_hilo", bus.hilo_out, 64'h00000007_FFFFFFFF);
    issue(DIVS, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n, lo);
    check("div_wrap_hilo", bus.hilo_out, 64'h00000000_80000000);
    bus.op_valid = 1'b1;
    bus.op       = MTHI;
    bus.rs_data  = 32'hA5A5_A5A5;
    #1;
    check("mthi_stall", 64'(bus.stall), 64'd0);
    tick;
    bus.op      = MTLO;
    bus.rs_data = 32'h1;
    #1;
    check("mtlo_stall", 64'(bus.stall), 64'd0);
    tick;
    bus.op_valid = 1'b0;
    check("mthi_mtlo_hilo", bus.hilo_out, 64'hA5A5A5A5_00000001);
    issue(DIVU, 32'd1000, 32'd3);
    repeat (9) tick;
    bus.flush = 1'b1;
    tick;
    bus.flush = 1'b0;
    check("flush_busy", 64'(bus.busy), 64'd0);
    check("flush_done", 64'(bus.done), 64'd0);
    tick;
    check("flush_done_late", 64'(bus.done), 64'd0);
    check("flush_hilo", bus.hilo_out, 64'hA5A5A5A5_00000001);
    issue(DIVS, 32'd7, 32'd0);
    bus.flush = 1'b1;
    tick;
    bus.flush = 1'b0;
    check("flush_fin_busy", 64'(bus.busy), 64'd0);
    check("flush_fin_done", 64'(bus.done), 64'd0);
    check("flush_fin_hilo", bus.hilo_out, 64'hA5A5A5A5_00000001);
    bus.op_valid = 1'b1;
    bus.op       = MTLO;
    bus.rs_data  = 32'h1234;
    bus.flush    = 1'b1;
    tick;
    bus.op_valid = 1'b0;
    bus.flush    = 1'b0;
    check("flush_idle_hilo", bus.hilo_out, 64'hA5A5A5A5_00000001);
    issue(DIVU, 32'd9, 32'd3);
    bus.op_valid = 1'b1;
    bus.op       = MTHI;
    bus.rs_data  = 32'hDEAD_BEEF;
    #1;
    check("busy_op_stall", 64'(bus.stall), 64'd1);
    check("busy_op_ready", 64'(bus.op_ready), 64'd0);
    tick;
    bus.op_valid = 1'b0;
    wait_idle(n, lo);
    check("busy_op_hilo", bus.hilo_out, {32'd0, 32'd3});
    issue(MULT, 32'd2, 32'd3);
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("rst_mid_hilo", bus.hilo_out, 64'd0);
    check("rst_mid_busy", 64'(bus.busy), 64'd0);
    check("rst_mid_ready", 64'(bus.op_ready), 64'd1);
    check("rst_mid_done", 64'(bus.done), 64'd0);
    mult_case("mult_again");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
